// File: rtl/sram_pkg.sv
// sram_pkg: shared types, read-during-write modes and lane-count helper for sram_dp_be_clr
package sram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic int num_lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: RD_LATENCY-stage valid/data delay line; data holds while no valid passes
module sram_rd_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [LATENCY-1:0] v;
  logic [WIDTH-1:0]   d [LATENCY];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign out_valid = v[LATENCY-1];
  assign out_data  = d[LATENCY-1];
endmodule

// File: rtl/sram_dp_be_clr.sv
// sram_dp_be_clr: simple dual-port SRAM with lane enables, RDW mode and hardware clear engine
module sram_dp_be_clr
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  err
);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic                  blocked, wr_ok, rd_ok, wr_in, rd_in;
  logic [DATA_WIDTH-1:0] wr_old, wr_word, rd_word;
  always_comb begin
    blocked  = state == CLEAR || clear;
    wr_ok    = write && !blocked;
    rd_ok    = read && !blocked;
    wr_in    = {1'b0, wr_addr} < LIMIT;
    rd_in    = {1'b0, rd_addr} < LIMIT;
    state_nx = clear ? CLEAR : (state == CLEAR && cnt == LAST) ? READY : state;
    cnt_nx   = (clear || state == READY) ? '0 : cnt + 1'b1;
    wr_old   = mem[wr_addr];
    wr_word  = wr_old;
    for (int l = 0; l < NUM_LANES; l++)
      wr_word[l*LANE_WIDTH +: LANE_WIDTH] = wr_be[l] ? wr_data[l*LANE_WIDTH +: LANE_WIDTH]
                                                     : wr_old[l*LANE_WIDTH +: LANE_WIDTH];
    rd_word  = !rd_in ? '0
             : (RDW_MODE == RDW_NEW && wr_ok && wr_in && wr_addr == rd_addr) ? wr_word
             : mem[rd_addr];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      wr_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_done <= wr_ok;
      err     <= (blocked && (read || write)) || (wr_ok && !wr_in) || (rd_ok && !rd_in);
    end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[cnt] <= CLEAR_VALUE;
    else if (wr_ok && wr_in) mem[wr_addr] <= wr_word;
  assign busy = state == CLEAR;
  sram_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_ok),
    .in_data  (rd_word),
    .out_valid(rd_done),
    .out_data (rd_data)
  );
endmodule

// File: tb/tb_sram_dp_be_clr.sv
// tb_sram_dp_be_clr: table-driven and directed checks over four parameter variants sharing stimulus
module tb_sram_dp_be_clr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cl = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [3:0] wa = '0, ra = '0;
  logic [15:0] wd = '0;
  logic [1:0] be = '0;
  logic [15:0] rdata [4];
  logic rdone [4], wdone [4], busy [4], err [4];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sram_dp_be_clr u0 (.clk(clk), .rst(rst), .clear(cl), .write(wr), .wr_addr(wa), .wr_data(wd),
    .wr_be(be), .read(rd), .rd_addr(ra), .rd_data(rdata[0]), .rd_done(rdone[0]),
    .wr_done(wdone[0]), .busy(busy[0]), .err(err[0]));
  sram_dp_be_clr #(.RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .clear(cl), .write(wr), .wr_addr(wa),
    .wr_data(wd), .wr_be(be), .read(rd), .rd_addr(ra), .rd_data(rdata[1]), .rd_done(rdone[1]),
    .wr_done(wdone[1]), .busy(busy[1]), .err(err[1]));
  sram_dp_be_clr #(.RD_LATENCY(2)) u2 (.clk(clk), .rst(rst), .clear(cl), .write(wr), .wr_addr(wa),
    .wr_data(wd), .wr_be(be), .read(rd), .rd_addr(ra), .rd_data(rdata[2]), .rd_done(rdone[2]),
    .wr_done(wdone[2]), .busy(busy[2]), .err(err[2]));
  sram_dp_be_clr #(.DEPTH(12)) u3 (.clk(clk), .rst(rst), .clear(cl), .write(wr), .wr_addr(wa),
    .wr_data(wd), .wr_be(be), .read(rd), .rd_addr(ra), .rd_data(rdata[3]), .rd_done(rdone[3]),
    .wr_done(wdone[3]), .busy(busy[3]), .err(err[3]));

  typedef struct {
    logic wr; logic [3:0] wa; logic [15:0] wd; logic [1:0] be;
    logic rd; logic [3:0] ra;
    logic e_rd; logic [15:0] e_d0; logic [15:0] e_d1; logic e_wd; logic e_err;
  } vec_t;
  vec_t tv [$];

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [15:0] d,
                              input logic [1:0] b, input logic r, input logic [3:0] q,
                              input logic erd, input logic [15:0] ed0, input logic [15:0] ed1,
                              input logic ewd, input logic eerr);
    vec_t v;
    v.wr = w; v.wa = a; v.wd = d; v.be = b; v.rd = r; v.ra = q;
    v.e_rd = erd; v.e_d0 = ed0; v.e_d1 = ed1; v.e_wd = ewd; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cl = 0; wr = 0; rd = 0; wa = '0; ra = '0; wd = '0; be = '0;
  endtask

  initial begin
    int first [4];
    int n;
    bit seen;
    #1 rst = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) chk($sformatf("rst_busy%0d", j), busy[j], 1);
    chk("rst_rd_done", rdone[0], 0);
    chk("rst_rd_data", rdata[0], 0);
    chk("rst_wr_done", wdone[0], 0);
    chk("rst_err", err[0], 0);
    step();
    step();
    chk("rst_hold_busy", busy[0], 1);
    @(negedge clk) rst = 1'b1;
    for (int j = 0; j < 4; j++) first[j] = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      for (int j = 0; j < 4; j++) if (!busy[j] && first[j] == 0) first[j] = k;
    end
    chk("init_clear_len0", first[0], 16);
    chk("init_clear_len1", first[1], 16);
    chk("init_clear_len2", first[2], 16);
    chk("init_clear_len3", first[3], 12);

    for (int i = 0; i < 16; i++) tv.push_back(mk(0, 0, 0, 0, 1, 4'(i), 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 3, 16'hABCD, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    tv.push_back(mk(1, 3, 16'h1234, 2'b01, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 3, 1, 16'hAB34, 16'hAB34, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'hAB34, 16'hAB34, 0, 0));
    tv.push_back(mk(1, 5, 16'h1111, 2'b11, 0, 0, 0, 16'hAB34, 16'hAB34, 1, 0));
    tv.push_back(mk(1, 5, 16'h2222, 2'b11, 1, 5, 1, 16'h1111, 16'h2222, 1, 0));
    tv.push_back(mk(1, 5, 16'hFFFF, 2'b00, 0, 0, 0, 16'h1111, 16'h2222, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 5, 1, 16'h2222, 16'h2222, 0, 0));
    tv.push_back(mk(1, 6, 16'h6666, 2'b11, 1, 3, 1, 16'hAB34, 16'hAB34, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 6, 1, 16'h6666, 16'h6666, 0, 0));
    foreach (tv[i]) begin
      wr = tv[i].wr; wa = tv[i].wa; wd = tv[i].wd; be = tv[i].be; rd = tv[i].rd; ra = tv[i].ra;
      step();
      chk($sformatf("v%0d_rd_done", i), rdone[0], tv[i].e_rd);
      chk($sformatf("v%0d_rd_data", i), rdata[0], tv[i].e_d0);
      chk($sformatf("v%0d_rd_data_rdw_new", i), rdata[1], tv[i].e_d1);
      chk($sformatf("v%0d_wr_done", i), wdone[0], tv[i].e_wd);
      chk($sformatf("v%0d_err", i), err[0], tv[i].e_err);
    end
    idle_inputs();
    step();

    rd = 1; ra = 3;
    step();
    rd = 0;
    chk("lat2_not_yet", rdone[2], 0);
    chk("lat1_done", rdone[0], 1);
    step();
    chk("lat2_done", rdone[2], 1);
    chk("lat2_data", rdata[2], 16'hAB34);
    chk("lat1_single_pulse", rdone[0], 0);

    wr = 1; wa = 13; wd = 16'h5555; be = 2'b11;
    step();
    chk("oor_wr_done", wdone[3], 1);
    chk("oor_wr_err", err[3], 1);
    chk("inrange_wr_err", err[0], 0);
    wr = 0; rd = 1; ra = 13;
    step();
    rd = 0;
    chk("oor_rd_done", rdone[3], 1);
    chk("oor_rd_data", rdata[3], 0);
    chk("oor_rd_err", err[3], 1);
    chk("inrange_rd_data", rdata[0], 16'h5555);
    step();
    chk("oor_err_pulse", err[3], 0);

    wr = 1; wa = 7; wd = 16'h7777; be = 2'b11;
    step();
    chk("pre_clear_wr_done", wdone[0], 1);
    cl = 1; wd = 16'h9999;
    step();
    cl = 0; wr = 0;
    chk("clear_wr_err", err[0], 1);
    chk("clear_wr_no_done", wdone[0], 0);
    chk("clear_busy", busy[0], 1);
    rd = 1; ra = 7;
    step();
    rd = 0;
    chk("busy_rd_err", err[0], 1);
    chk("busy_rd_no_done", rdone[0], 0);
    n = 2;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!busy[0]) break;
      n++;
    end
    chk("clear_busy_len", n, 16);
    rd = 1; ra = 7;
    step();
    rd = 0;
    chk("post_clear_rd_done", rdone[0], 1);
    chk("post_clear_rd_data", rdata[0], 0);

    wr = 1; wa = 3; wd = 16'hBEEF; be = 2'b11;
    step();
    wr = 0; rd = 1; ra = 3;
    step();
    rd = 0;
    chk("flush_pending", rdone[2], 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rd_done0", rdone[0], 0);
    chk("async_rd_data0", rdata[0], 0);
    chk("async_rd_done2", rdone[2], 0);
    chk("async_busy2", busy[2], 1);
    chk("async_err2", err[2], 0);
    chk("async_wr_done2", wdone[2], 0);
    step();
    chk("flush_dropped", rdone[2], 0);
    @(negedge clk) rst = 1'b1;
    n = 0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rdone[2]) seen = 1;
      if (!busy[2]) begin
        n = k;
        break;
      end
    end
    chk("reclear_len", n, 16);
    chk("flush_never_done", seen, 0);
    rd = 1; ra = 3;
    step();
    rd = 0;
    step();
    chk("reclear_rd_done", rdone[2], 1);
    chk("reclear_rd_data", rdata[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_dp_be_clr.md
Name: sram_dp_be_clr

Overview:
- Parametrised successor to the team's 16x4 SRAM: simple dual-port (one write port, one read port) synchronous memory.
- Adds lane write-enables, configurable read latency and read-during-write mode, and a hardware clear engine that initialises the array after reset or on request.
- Used as a generic scratch/buffer memory; exposes per-access done pulses and an error flag to the requesting controller.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of words; DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write: 0 = old data, 1 = new (merged) data.
- CLEAR_VALUE, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  request full-array clear.
- write  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NUM_LANES  lane enables; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH].
- read  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_done  out  1  read-data-valid pulse.
- wr_done  out  1  write-accepted pulse.
- busy  out  1  clear engine active.
- err  out  1  rejected or out-of-range access pulse.

Behaviour:
- Reset:
  - rst low asynchronously forces rd_data=0, rd_done=0, wr_done=0, err=0, busy=1.
  - Read pipeline is flushed; pending rd_done is dropped.
  - FSM enters CLEAR with clear counter = 0. Array contents are not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR: each clock writes CLEAR_VALUE to address counter, then counter+1. After address DEPTH-1, next state is READY. Takes exactly DEPTH cycles; busy=1 throughout, busy=0 the cycle READY is entered.
  - READY -> CLEAR when clear=1 is sampled. Counter is loaded to 0 and busy=1 from the next cycle.
  - clear=1 while already in CLEAR restarts the counter at 0.
- Accesses during CLEAR, or in the same cycle clear is sampled in READY:
  - read/write are ignored; no memory update.
  - wr_done and rd_done stay 0.
  - err=1 next cycle for each such cycle with read or write high.
- Write (READY, write=1):
  - At that edge, every lane with wr_be set is updated from wr_data; other lanes are unchanged.
  - wr_done=1 the following cycle (registered); stays high across back-to-back writes.
  - wr_be=0 still counts as accepted: wr_done=1, no change to memory.
- Read (READY, read=1):
  - rd_data and rd_done appear RD_LATENCY cycles after the request edge.
  - rd_done is high for one cycle per request; back-to-back reads give back-to-back rd_done.
  - rd_data holds its last value when rd_done=0.
- Same-address read and write in one cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled lanes from wr_data, other lanes old.
  - Read and write to different addresses are fully independent.
- Out-of-range address (>= DEPTH):
  - Write: no update; wr_done=1 and err=1.
  - Read: rd_data=0 and rd_done=1 at normal latency, err=1 one cycle after the request.
- err: registered, one cycle per offending request cycle. Write and read errors in the same cycle produce a single err pulse.

Decomposition:
- sram_pkg: state enum (CLEAR, READY), RDW_OLD/RDW_NEW constants, NUM_LANES helper function.
- Sub-module sram_rd_pipe: valid/data delay line of RD_LATENCY stages carrying rd_done and rd_data; flushed by rst.
- Top level holds the array, write-lane merge, RDW bypass mux and clear FSM.

Test Plan:
- Reset release -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 each return 0x0000 with rd_done pulses.
- Write addr 3 = 0xABCD, be=2'b11; then write addr 3 = 0x1234, be=2'b01; read addr 3 -> 0xAB34; wr_done 1 cycle after each write; rd_done at latency 1, and at latency 2 with RD_LATENCY=2.
- RDW_MODE=0: addr 5 = 0x1111; then same-cycle write 0x2222/be=11 and read of addr 5 -> rd_data=0x1111. RDW_MODE=1, same stimulus -> 0x2222.
- clear pulse in READY with a simultaneous write to addr 7 -> err=1, no wr_done, busy=1 for 16 cycles; read addr 7 afterwards -> 0x0000.
- DEPTH=12, ADDR_WIDTH=4: write addr 13 -> wr_done=1, err=1; read addr 13 -> rd_data=0, rd_done=1, err=1.
- Issue read, assert rst low before rd_done (RD_LATENCY=2) -> rd_done never pulses, all outputs 0, busy=1 asynchronously; clear restarts from address 0 after release.
